// File: rtl/prog_timer_if.sv
// CPU register-bus signals for prog_timer: write strobe, register select, write data.
interface prog_timer_if;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] din;

    modport master (output wr, addr, din);
    modport slave  (input  wr, addr, din);
endinterface

// File: rtl/prog_timer.sv
// 16-bit programmable down-counting interval timer with reload register, one-shot/continuous modes
// and latched interrupt. Optional tick prescaler enabled by defining PROG_TIMER_PRESCALE_EN.
module prog_timer (
    input  logic         MasterClock,
    input  logic         RESETL,
    prog_timer_if.slave  bus,
    input  logic         tick,
    input  logic         intack,
    output logic [15:0]  count,
    output logic         tc,
    output logic         irq,
    output logic         running
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] reload_q;
    logic [15:0] reload_d;
    logic [15:0] count_q;
    logic        cont_q;
    logic        irqen_q;
    logic        tc_q;
    logic        irq_q;

    logic        ctrl_wr;
    logic        start_cmd;
    logic        step;
    logic        at_zero;
    logic        tc_set;

    assign ctrl_wr   = bus.wr && (bus.addr == 2'd2);
    assign start_cmd = bus.din[0];
    assign at_zero   = (count_q == '0);

`ifdef PROG_TIMER_PRESCALE_EN
    logic [7:0] pscale_q;
    logic [7:0] pcnt_q;

    // >= rather than == keeps the divider from running away if P shrinks mid-count
    assign step = tick && (pcnt_q >= pscale_q);

    always_ff @(posedge MasterClock or negedge RESETL) begin
        if (!RESETL) begin
            pscale_q <= '0;
        end else if (bus.wr && (bus.addr == 2'd3)) begin
            pscale_q <= bus.din;
        end
    end
`else
    assign step = tick;
`endif

    // A control write in RUN pre-empts the count step, so it can never produce tc.
    assign tc_set = (state_q == S_RUN) && !ctrl_wr && step && at_zero;

    always_comb begin
        reload_d = reload_q;
        if (bus.wr && (bus.addr == 2'd0)) reload_d[7:0]  = bus.din;
        if (bus.wr && (bus.addr == 2'd1)) reload_d[15:8] = bus.din;
    end

    always_ff @(posedge MasterClock or negedge RESETL) begin
        if (!RESETL) begin
            state_q  <= S_IDLE;
            reload_q <= '0;
            count_q  <= '0;
            cont_q   <= 1'b0;
            irqen_q  <= 1'b0;
            tc_q     <= 1'b0;
            irq_q    <= 1'b0;
`ifdef PROG_TIMER_PRESCALE_EN
            pcnt_q   <= '0;
`endif
        end else begin
            tc_q     <= tc_set;
            reload_q <= reload_d;

            if (ctrl_wr) begin
                cont_q  <= bus.din[1];
                irqen_q <= bus.din[2];
            end

            case (state_q)
                S_IDLE: begin
                    if (ctrl_wr && start_cmd) state_q <= S_LOAD;
                end
                S_LOAD: begin
                    count_q <= reload_q;
                    state_q <= S_RUN;
`ifdef PROG_TIMER_PRESCALE_EN
                    pcnt_q  <= '0;
`endif
                end
                S_RUN: begin
                    if (ctrl_wr) begin
                        state_q <= start_cmd ? S_LOAD : S_IDLE;
                    end else if (step) begin
                        if (at_zero) begin
                            if (cont_q) count_q <= reload_q;
                            else        state_q <= S_IDLE;
                        end else begin
                            count_q <= count_q - 16'd1;
                        end
                    end
`ifdef PROG_TIMER_PRESCALE_EN
                    if (!ctrl_wr && tick) pcnt_q <= step ? '0 : pcnt_q + 8'd1;
`endif
                end
                default: state_q <= S_IDLE;
            endcase

            if (tc_set && irqen_q) irq_q <= 1'b1;
            else if (intack)       irq_q <= 1'b0;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign irq     = irq_q;
    assign running = (state_q == S_RUN);

endmodule
